logic_unit_pipe: RTL and testbench

Parametrised, pipelined successor to the basic two-input gate block. It computes one of eight bitwise logic operations on WIDTH-bit operands, with a valid-tagged pipeline of configurable depth. It adds an accumulate mode in which operand B is replaced by an internal result register, so chained reductions are possible. It also provides zero and parity status flags on the result. It sits between the operand source (switches/registers) and the display/result sinks of the lab datapath.

---
 rtl/logic_unit_pkg.sv | 18 +
 rtl/logic_op_core.sv | 29 ++
 rtl/logic_unit_pipe.sv | 89 ++++++++
 tb/tb_logic_unit_pipe.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared op codes and parameter limits for the bitwise logic unit and its users.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 32;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

endpackage

// File: rtl/logic_op_core.sv
// Combinational eight-way bitwise operator on WIDTH-bit operands.
// Zero latency; no flow control, output follows inputs.
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic [WIDTH-1:0] oY
);

  always_comb begin
    oY = iA;
    case (iOp)
      OP_AND:  oY = iA & iB;
      OP_OR:   oY = iA | iB;
      OP_NOT:  oY = ~iA;
      OP_NAND: oY = ~(iA & iB);
      OP_NOR:  oY = ~(iA | iB);
      OP_XOR:  oY = iA ^ iB;
      OP_XNOR: oY = ~(iA ^ iB);
      OP_PASS: oY = iA;
      default: oY = iA;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with accumulator and zero/parity flags.
// Latency STAGES cycles, one op per cycle; no backpressure, results cannot stall.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  input  logic [2:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iAcc,
  input  logic             iClr,
  output logic             oValid,
  output logic [WIDTH-1:0] oY,
  output logic             oZero,
  output logic             oParity,
  output logic [WIDTH-1:0] oAcc
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : gBadParam
    $error("logic_unit_pipe: WIDTH or STAGES out of range");
  end

  logic [WIDTH-1:0] accQ;
  logic [WIDTH-1:0] accOperand;
  logic [WIDTH-1:0] bOperand;
  logic [WIDTH-1:0] opResult;

  // A clear in the same cycle as an accumulate op zeroes the operand, not just the register.
  assign accOperand = iClr ? '0 : accQ;
  assign bOperand   = iAcc ? accOperand : iB;

  logic_op_core #(
    .WIDTH (WIDTH)
  ) uOpCore (
    .iOp (iOp),
    .iA  (iA),
    .iB  (bOperand),
    .oY  (opResult)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      accQ <= '0;
    end else if (iValid && iAcc) begin
      accQ <= opResult;
    end else if (iClr) begin
      accQ <= '0;
    end
  end

  // Index 0 is the unregistered stage-1 input; index k is the output of stage k.
  logic [STAGES:0]            validChain;
  logic [STAGES:0][WIDTH-1:0] dataChain;

  assign validChain[0] = iValid;
  assign dataChain[0]  = opResult;

  for (genvar k = 1; k <= STAGES; k++) begin : gStage
    logic             validQ;
    logic [WIDTH-1:0] dataQ;

    always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
        validQ <= 1'b0;
        dataQ  <= '0;
      end else begin
        validQ <= validChain[k-1];
        if (validChain[k-1]) begin
          dataQ <= dataChain[k-1];
        end
      end
    end

    assign validChain[k] = validQ;
    assign dataChain[k]  = dataQ;
  end

  assign oValid  = validChain[STAGES];
  assign oY      = dataChain[STAGES];
  assign oZero   = ~|oY;
  assign oParity = ^oY;
  assign oAcc    = accQ;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: default, STAGES=1, STAGES=4/WIDTH=32 and WIDTH=1 instances share stimulus.
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [2:0]  op;
  logic [31:0] a32;
  logic [31:0] b32;
  logic        accMode;
  logic        clr;

  always #5 clk = ~clk;

  logic       v8, z8, p8;
  logic [7:0] y8, acc8;
  logic       vS1, zS1, pS1;
  logic [7:0] yS1, accS1;
  logic        v32, z32, p32;
  logic [31:0] y32, acc32;
  logic vW1, yW1, zW1, pW1, accW1;

  logic_unit_pipe #(.WIDTH(8), .STAGES(2)) uDut (
    .iClk(clk), .iRst(rst), .iValid(valid), .iOp(op), .iA(a32[7:0]), .iB(b32[7:0]),
    .iAcc(accMode), .iClr(clr), .oValid(v8), .oY(y8), .oZero(z8), .oParity(p8), .oAcc(acc8));

  logic_unit_pipe #(.WIDTH(8), .STAGES(1)) uDutS1 (
    .iClk(clk), .iRst(rst), .iValid(valid), .iOp(op), .iA(a32[7:0]), .iB(b32[7:0]),
    .iAcc(accMode), .iClr(clr), .oValid(vS1), .oY(yS1), .oZero(zS1), .oParity(pS1), .oAcc(accS1));

  logic_unit_pipe #(.WIDTH(32), .STAGES(4)) uDut32 (
    .iClk(clk), .iRst(rst), .iValid(valid), .iOp(op), .iA(a32), .iB(b32),
    .iAcc(accMode), .iClr(clr), .oValid(v32), .oY(y32), .oZero(z32), .oParity(p32), .oAcc(acc32));

  logic_unit_pipe #(.WIDTH(1), .STAGES(2)) uDutW1 (
    .iClk(clk), .iRst(rst), .iValid(valid), .iOp(op), .iA(a32[0]), .iB(b32[0]),
    .iAcc(accMode), .iClr(clr), .oValid(vW1), .oY(yW1), .oZero(zW1), .oParity(pW1), .oAcc(accW1));

  int testsRun    = 0;
  int testsFailed = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hand-computed results for A=C5, B=3A (8-bit), the same zero-extended to 32 bits, and their LSBs.
  logic [7:0]  exp8  [8] = '{8'h00, 8'hFF, 8'h3A, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hC5};
  logic [31:0] exp32 [8] = '{32'h00000000, 32'h000000FF, 32'hFFFFFF3A, 32'hFFFFFFFF,
                             32'hFFFFFF00, 32'h000000FF, 32'hFFFFFF00, 32'h000000C5};
  logic        exp1  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic am, input logic c);
    valid = v; op = o; a32 = a; b32 = b; accMode = am; clr = c;
  endtask

  initial begin
    int idx;
    rst = 1'b1;
    drive(1'b0, OP_AND, 32'h0, 32'h0, 1'b0, 1'b0);
    #12;
    checkVal("rst oValid", {31'b0, v8}, 32'h0);
    checkVal("rst oY", {24'b0, y8}, 32'h0);
    checkVal("rst oZero", {31'b0, z8}, 32'h1);
    checkVal("rst oParity", {31'b0, p8}, 32'h0);
    checkVal("rst oAcc", {24'b0, acc8}, 32'h0);
    checkVal("rst32 oZero", {31'b0, z32}, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // Op sweep, back-to-back, checked on every instance against its own latency.
    for (int j = 0; j < 12; j++) begin
      drive(j < 8, j[2:0], 32'h000000C5, 32'h0000003A, 1'b0, 1'b0);
      cycle();
      idx = j - 1;
      if (idx >= 0 && idx < 8) begin
        checkVal($sformatf("sweep8 oValid op%0d", idx), {31'b0, v8}, 32'h1);
        checkVal($sformatf("sweep8 oY op%0d", idx), {24'b0, y8}, {24'b0, exp8[idx]});
        checkVal($sformatf("sweep8 oZero op%0d", idx), {31'b0, z8}, {31'b0, exp8[idx] == 8'h00});
        checkVal($sformatf("sweepW1 oY op%0d", idx), {31'b0, yW1}, {31'b0, exp1[idx]});
        checkVal($sformatf("sweepW1 oValid op%0d", idx), {31'b0, vW1}, 32'h1);
      end else begin
        checkVal($sformatf("sweep8 idle oValid j%0d", j), {31'b0, v8}, 32'h0);
      end
      idx = j;
      if (idx < 8) begin
        checkVal($sformatf("sweepS1 oValid op%0d", idx), {31'b0, vS1}, 32'h1);
        checkVal($sformatf("sweepS1 oY op%0d", idx), {24'b0, yS1}, {24'b0, exp8[idx]});
      end else begin
        checkVal($sformatf("sweepS1 idle oValid j%0d", j), {31'b0, vS1}, 32'h0);
      end
      idx = j - 3;
      if (idx >= 0 && idx < 8) begin
        checkVal($sformatf("sweep32 oValid op%0d", idx), {31'b0, v32}, 32'h1);
        checkVal($sformatf("sweep32 oY op%0d", idx), y32, exp32[idx]);
      end else begin
        checkVal($sformatf("sweep32 idle oValid j%0d", j), {31'b0, v32}, 32'h0);
      end
    end

    // Bubbles: OR 0F|30, gap, OR 01|02.
    drive(1'b1, OP_OR, 32'h0F, 32'h30, 1'b0, 1'b0);
    cycle();
    drive(1'b0, OP_OR, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    checkVal("bubble oValid #1", {31'b0, v8}, 32'h1);
    checkVal("bubble oY #1", {24'b0, y8}, 32'h3F);
    drive(1'b1, OP_OR, 32'h01, 32'h02, 1'b0, 1'b0);
    cycle();
    checkVal("bubble oValid gap", {31'b0, v8}, 32'h0);
    checkVal("bubble oY held", {24'b0, y8}, 32'h3F);
    drive(1'b0, OP_OR, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    checkVal("bubble oValid #2", {31'b0, v8}, 32'h1);
    checkVal("bubble oY #2", {24'b0, y8}, 32'h03);

    // Accumulator chain.
    drive(1'b0, OP_AND, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle();
    checkVal("acc clear idle", {24'b0, acc8}, 32'h00);
    drive(1'b1, OP_OR, 32'h0F, 32'hAA, 1'b1, 1'b0);
    cycle();
    checkVal("acc OR 0F", {24'b0, acc8}, 32'h0F);
    drive(1'b1, OP_XOR, 32'hF0, 32'h55, 1'b1, 1'b0);
    cycle();
    checkVal("acc XOR F0", {24'b0, acc8}, 32'hFF);
    checkVal("acc oY OR", {24'b0, y8}, 32'h0F);
    drive(1'b1, OP_AND, 32'h12, 32'h34, 1'b0, 1'b0);
    cycle();
    checkVal("acc held by plain op", {24'b0, acc8}, 32'hFF);
    checkVal("acc oY XOR", {24'b0, y8}, 32'hFF);
    drive(1'b1, OP_AND, 32'h01, 32'hFF, 1'b1, 1'b1);
    cycle();
    checkVal("acc AND with clr", {24'b0, acc8}, 32'h00);
    checkVal("acc oY plain AND", {24'b0, y8}, 32'h10);
    drive(1'b0, OP_AND, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    checkVal("acc oY cleared operand", {24'b0, y8}, 32'h00);
    checkVal("acc oZero cleared operand", {31'b0, z8}, 32'h1);

    // Flags.
    drive(1'b1, OP_PASS, 32'h07, 32'h0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, OP_PASS, 32'h00, 32'h0, 1'b0, 1'b0);
    cycle();
    checkVal("flags 07 oParity", {31'b0, p8}, 32'h1);
    checkVal("flags 07 oZero", {31'b0, z8}, 32'h0);
    drive(1'b0, OP_AND, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    checkVal("flags 00 oParity", {31'b0, p8}, 32'h0);
    checkVal("flags 00 oZero", {31'b0, z8}, 32'h1);

    // 32-bit NOT through the 4-deep pipe.
    drive(1'b1, OP_NOT, 32'h0000FFFF, 32'h0, 1'b0, 1'b0);
    cycle();
    checkVal("S1 NOT FF oY", {24'b0, yS1}, 32'h00);
    drive(1'b0, OP_AND, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    checkVal("W1 NOT 1 oY", {31'b0, yW1}, 32'h0);
    cycle();
    checkVal("w32 oValid before latency", {31'b0, v32}, 32'h0);
    cycle();
    checkVal("w32 oValid at latency", {31'b0, v32}, 32'h1);
    checkVal("w32 NOT oY", y32, 32'hFFFF0000);
    checkVal("w32 NOT oParity", {31'b0, p32}, 32'h0);
    checkVal("w32 NOT oZero", {31'b0, z32}, 32'h0);

    // Reset mid-stream with two ops in flight.
    drive(1'b1, OP_OR, 32'h5A, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkVal("pre-rst oAcc", {24'b0, acc8}, 32'h5A);
    drive(1'b1, OP_PASS, 32'h3C, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkVal("midrst oValid", {31'b0, v8}, 32'h0);
    checkVal("midrst oY", {24'b0, y8}, 32'h0);
    checkVal("midrst oZero", {31'b0, z8}, 32'h1);
    checkVal("midrst oParity", {31'b0, p8}, 32'h0);
    checkVal("midrst oAcc", {24'b0, acc8}, 32'h0);
    drive(1'b0, OP_AND, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cycle();
      checkVal($sformatf("post-rst oValid c%0d", j), {31'b0, v8}, 32'h0);
      checkVal($sformatf("post-rst oY c%0d", j), {24'b0, y8}, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
